alu_reg_pipe: RTL
=================

ALU_REG_PIPE -- requirements
Module: alu_reg_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the datapath and register width.
REQ-002 The block SHALL have parameter NREG, default 32, the register count (power of two, >=2); AW = clog2(NREG) is derived, not a parameter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operation offered this cycle.
REQ-006 The block SHALL have port in_ready  output  1  operation accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 The block SHALL have ports r_addr_a, r_addr_b  input  AW  source register addresses.
REQ-008 The block SHALL have ports w_addr  input  AW  destination address, and w_en  input  1  writeback enable.
REQ-009 The block SHALL have port alu_op  input  4  operation code.
REQ-010 The block SHALL have ports res  output  XLEN  registered result, flags  output  4  registered {Z,C,V,N} (flags[3]=Z … flags[0]=N), and out_valid  output  1  one-cycle result strobe.

Function
REQ-011 Two stages SHALL be used: issue edge E0 captures op, w_addr, w_en and both operands into stage 1; edge E1 registers res/flags, pulses out_valid for one cycle, and, if captured w_en=1, writes the result to the register file.
REQ-012 Accepted operations SHALL issue one per cycle; output latency is exactly one cycle after the issue edge, in issue order.
REQ-013 Register 0 SHALL read as zero; writes to address 0 are discarded.
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 SRA, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1010 XOR, 1100 NOR; every other code yields res=0 (flags computed on it, writeback still performed if w_en).
REQ-015 Shift amount SHALL be the low clog2(XLEN) bits of operand B; SLT/SLTU yield 0 or 1 zero-extended.
REQ-016 Z SHALL equal (res==0) and N SHALL equal res[XLEN-1] for all ops; C and V are valid for ADD/SUB only (C = carry-out of A+B or A+~B+1; V = signed overflow) and zero otherwise.
REQ-017 Arithmetic SHALL wrap modulo 2^XLEN.
REQ-018 Read-after-write hazard: an operation issuing at E1 that reads the nonzero w_addr of a stage-1 operation with w_en=1 is handled per REQ-023/REQ-024; operations issuing at E2 or later read the updated register file directly.
REQ-019 When in_valid is low at an edge, stage 1 SHALL become empty and out_valid SHALL be 0 in the following cycle; res/flags hold their last values.

Reset
REQ-020 rst_n low SHALL immediately clear out_valid, res and flags to 0, empty stage 1, and load register i with value i for i=1..NREG-1.
REQ-021 An operation in flight when reset asserts SHALL be discarded: no writeback, no out_valid.
REQ-022 in_ready SHALL be 1 during reset and in the first cycle after release.

Configuration
REQ-023 With ALU_FWD_EN defined, the hazard of REQ-018 SHALL be resolved by bypassing the stage-1 ALU result into the operand capture; in_ready is constant 1.
REQ-024 Without ALU_FWD_EN, in_ready SHALL be 0 for exactly the cycle in which in_valid is high and a source address (a or b, nonzero) matches stage-1 w_addr with stage-1 w_en=1; the operation issues on the next edge.

Verification
REQ-025 Reset, issue ADD r1,r2->r3 w_en=1 -> next cycle out_valid=1, res=3, flags=0000; later ADD r3,r0 returns 3.
REQ-026 Issue ADD r1,r2->r3 then SUB r3,r1->r4 on consecutive cycles -> with ALU_FWD_EN res=3 then res=2 on consecutive cycles; without, in_ready low one cycle, res=2 one cycle later.
REQ-027 SUB r5,r5->r6 -> res=0, flags Z=1 C=1 V=0 N=0.
REQ-028 ADD r1,r1->r0 w_en=1, then ADD r0,r0 -> res=0, Z=1.
REQ-029 SLL r1,r31->r7 (XLEN=32) -> res=0x80000000, N=1; then ADD r7,r7 -> res=0, Z=1 C=1 V=1 N=0.
REQ-030 Assert rst_n low one cycle after issuing ADD r1,r2->r9 -> out_valid never pulses for it, r9 reads 9.

Source files
------------

// File: rtl/alu_reg_pipe.sv
// alu_reg_pipe: two-stage ALU over a register file with registered result and {Z,C,V,N} flags.
// Define ALU_FWD_EN to bypass the stage-1 result into operand capture instead of stalling one cycle.
module alu_reg_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   r_addr_a,
    input  logic [AW-1:0]   r_addr_b,
    input  logic [AW-1:0]   w_addr,
    input  logic            w_en,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] res,
    output logic [3:0]      flags,
    output logic            out_valid
);
    localparam int SH = $clog2(XLEN);

    logic [XLEN-1:0] rf [NREG];
    logic            s1_valid, s1_wen, s1_wr, issue, hit_a, hit_b, is_add, is_sub;
    logic [3:0]      s1_op, alu_flags;
    logic [AW-1:0]   s1_waddr;
    logic [XLEN-1:0] s1_a, s1_b, rf_a, rf_b, opa, opb, alu_res;
    logic [XLEN:0]   sum, diff;

    assign s1_wr = s1_valid && s1_wen && s1_waddr != '0;
    assign hit_a = s1_wr && r_addr_a == s1_waddr;
    assign hit_b = s1_wr && r_addr_b == s1_waddr;
    assign rf_a  = r_addr_a == '0 ? '0 : rf[r_addr_a];
    assign rf_b  = r_addr_b == '0 ? '0 : rf[r_addr_b];
    assign issue = in_valid && in_ready;

`ifdef ALU_FWD_EN
    assign in_ready = 1'b1;
    assign opa = hit_a ? alu_res : rf_a;
    assign opb = hit_b ? alu_res : rf_b;
`else
    // The stalled op re-presents next cycle, when stage 1 is empty and the write has landed.
    assign in_ready = !(in_valid && (hit_a || hit_b));
    assign opa = rf_a;
    assign opb = rf_b;
`endif

    assign sum    = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff   = {1'b0, s1_a} + {1'b0, ~s1_b} + (XLEN+1)'(1);
    assign is_add = s1_op == 4'b0010;
    assign is_sub = s1_op == 4'b0110;

    always_comb begin
        alu_res = '0;
        case (s1_op)
            4'b0000: alu_res = s1_a & s1_b;
            4'b0001: alu_res = s1_a | s1_b;
            4'b0010: alu_res = sum[XLEN-1:0];
            4'b0011: alu_res = s1_a << s1_b[SH-1:0];
            4'b0100: alu_res = s1_a >> s1_b[SH-1:0];
            4'b0101: alu_res = $signed(s1_a) >>> s1_b[SH-1:0];
            4'b0110: alu_res = diff[XLEN-1:0];
            4'b0111: alu_res = XLEN'($signed(s1_a) < $signed(s1_b));
            4'b1000: alu_res = XLEN'(s1_a < s1_b);
            4'b1010: alu_res = s1_a ^ s1_b;
            4'b1100: alu_res = ~(s1_a | s1_b);
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {
        alu_res == '0,
        is_add ? sum[XLEN] : is_sub && diff[XLEN],
        is_add ? (s1_a[XLEN-1] == s1_b[XLEN-1]) && (sum[XLEN-1] != s1_a[XLEN-1])
               : is_sub && (s1_a[XLEN-1] != s1_b[XLEN-1]) && (diff[XLEN-1] != s1_a[XLEN-1]),
        alu_res[XLEN-1]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_wen    <= 1'b0;
            s1_op     <= '0;
            s1_waddr  <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            res       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= issue;
            out_valid <= s1_valid;
            if (issue) begin
                s1_wen   <= w_en;
                s1_op    <= alu_op;
                s1_waddr <= w_addr;
                s1_a     <= opa;
                s1_b     <= opb;
            end
            if (s1_valid) begin
                res   <= alu_res;
                flags <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= XLEN'(i);
        end else if (s1_wr) begin
            rf[s1_waddr] <= alu_res;
        end
    end
endmodule
